// File: rtl/seq_pow_poly.sv
// seq_pow_poly: sequential unsigned power unit, result_out = x_in ** e_in.
// Accepts a request on start && ready, iterates one multiply per cycle,
// and pulses done when result_out / ovf are valid. Overflow either wraps
// modulo 2^RW (SAT=0) or saturates to all ones (SAT=1).
module seq_pow_poly #(
    parameter int unsigned XW  = 4,
    parameter int unsigned EW  = 3,
    parameter int unsigned RW  = 16,
    parameter int unsigned SAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x_in,
    input  logic [EW-1:0] e_in,
    output logic          ready,
    output logic          done,
    output logic [RW-1:0] result_out,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    xr_q, xr_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [EW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [RW-1:0]    result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [RW+XW-1:0] prod;
    logic             step_ovf;

    // Next-state, datapath step and result capture on entry to DONE
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        prod     = {{XW{1'b0}}, acc_q} * {{RW{1'b0}}, xr_q};
        step_ovf = |prod[RW+XW-1:RW];

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    xr_d     = x_in;
                    sticky_d = 1'b0;
                    if (e_in == '0) begin
                        acc_d   = RW'(1);
                        state_d = DONE;
                    end else if (e_in == EW'(1)) begin
                        acc_d   = RW'(x_in);
                        state_d = DONE;
                    end else begin
                        acc_d   = RW'(x_in);
                        cnt_d   = e_in - EW'(1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                sticky_d = sticky_q | step_ovf;
                if ((SAT != 0) && sticky_d) begin
                    acc_d = '1;
                end else begin
                    acc_d = prod[RW-1:0];
                end
                cnt_d = cnt_q - EW'(1);
                if (cnt_q == EW'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Whichever path enters DONE, publish the final accumulator/sticky
        if (state_d == DONE) begin
            result_d = acc_d;
            ovf_d    = sticky_d;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready      = (state_q != CALC);
    assign done       = (state_q == DONE);
    assign result_out = result_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/seq_pow_poly.md
Name: seq_pow_poly

Overview:
- Sequential integer power unit computing y = x^e.
- Successor to the fixed-cube sequential block, with these generalisations:
  - Operand width is parametrised.
  - The exponent is supplied at run time, per request.
  - Result width is parametrised, with overflow detection and an optional saturation mode.
  - A start/ready/done handshake allows back-to-back requests.
- Sits in the polynomial datapath as the shared power-term generator feeding the coefficient MAC stage.

Parameters:
- XW, 4, width of operand x_in (unsigned).
- EW, 3, width of exponent e_in (unsigned); max exponent 2^EW-1.
- RW, 16, width of result_out (unsigned); must be >= XW.
- SAT, 0, overflow mode.
  - 0: result wraps, i.e. modulo 2^RW.
  - 1: result saturates to all ones.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request strobe; accepted when start && ready.
- x_in  input  XW  base operand; sampled at accept edge.
- e_in  input  EW  exponent; sampled at accept edge.
- ready  output  1  high when a new request can be accepted (state != CALC).
- done  output  1  one-cycle pulse; result_out and ovf valid.
- result_out  output  RW  x^e result; held until the next done.
- ovf  output  1  result exceeded 2^RW-1 during this computation; held with result_out.

Behaviour:
- Reset and clocking
  - One clock domain. Reset is synchronous, active-low.
  - On reset: state=IDLE, result_out=0, ovf=0, done=0, ready=1, internal acc/cnt/x register=0.
  - Reset asserted mid-operation aborts the computation. No done pulse is produced for the aborted request.
- States
  - IDLE: ready=1, done=0.
  - CALC: ready=0, done=0.
  - DONE: ready=1, done=1 for exactly one cycle.
- Accept (start && ready, in IDLE or DONE)
  - Latch x into xr.
  - e==0: acc=1, next state DONE.
  - e==1: acc=x, next state DONE.
  - e>=2: acc=x, cnt=e-1, next state CALC.
  - Clear the internal sticky overflow.
- CALC, each cycle
  - Form the full product p = acc*xr, RW+XW bits wide.
  - Overflow: set sticky if p[RW+XW-1:RW] != 0.
  - SAT=0: acc=p[RW-1:0].
  - SAT=1: acc = all ones if sticky or this-cycle overflow, else p[RW-1:0]; once saturated, acc stays all ones.
  - cnt decrements. On the cycle cnt==1, next state is DONE.
- Entering DONE
  - result_out and ovf load from the final acc and sticky value.
  - They hold until the next DONE entry or reset.
- Latency
  - Accept at edge T0 → done high in the cycle after edge T0+max(e-1,0).
  - Consequence: e<=1 gives 1 cycle; otherwise e-1 cycles, i.e. e-1 multiply steps.
- Throughput and ignored starts
  - start during CALC is ignored, with no effect on the computation in flight.
  - start in the DONE cycle is accepted: back-to-back operation, with done for request N and accept of N+1 in the same cycle.
  - start in IDLE is accepted normally.
- Edge cases
  - 0^0 = 1 with ovf=0.
  - x=0 with e>=1 gives 0.
  - Inputs x_in/e_in are don't-care when not accepted.
- Width rules
  - All arithmetic is unsigned.
  - Truncation to RW bits per step is equivalent to the final result mod 2^RW.

Test Plan (XW=4, EW=3, RW=16 unless stated):
1. SAT=0; reset, then start with x=2, e=3 → ready=0 for 2 cycles, done pulses 1 cycle, result_out=8, ovf=0; ready=1 in done cycle; result_out holds 8 afterwards.
2. SAT=0; x=9, e=0 then x=0, e=0 then x=5, e=1 → each done 1 cycle after accept with results 1, 1, 5; ovf=0.
3. SAT=0; x=15, e=7 → done after 6 CALC cycles, result_out=7023 (0x1B6F), ovf=1. Rerun with SAT=1 → result_out=0xFFFF, ovf=1. Then x=3, e=2 → 9, ovf=0, confirming sticky clears per request.
4. SAT=0; x=3, e=4 accepted, start pulsed with x=7, e=7 during CALC → ignored; done gives 81. Then x=2, e=5 asserted in the done cycle → accepted, next done gives 32.
5. SAT=0; x=15, e=7 accepted, rst_n low for 1 cycle after 3 CALC cycles → next cycle: ready=1, done=0, result_out=0, ovf=0, no later done. A following x=4, e=2 → 16.
